// File: rtl/vfu_sched.sv
// vfu_sched: iteration scheduler for the LDPC variable-node functional unit.
// Launches each check-node phase, sweeps all column groups through the vn4
// datapath one read per cycle, replays the reads as write-backs after the
// memory + vn4 register latency, and ends the decode on syndrome pass or
// on the iteration limit.
module vfu_sched #(
    parameter int COLS     = 64,
    parameter int ADDR_W   = 6,
    parameter int RD_LAT   = 2,
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              cn_start,
    input  logic              cn_done,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              syndrome_ok,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(COLS - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CN_WAIT,
        S_VN_RD,
        S_VN_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic              cn_start_reg, cn_start_next;
    logic              done_reg, done_next;
    logic              success_reg, success_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic              busy_reg, busy_next;
    logic              flush;

    // Write-back pipeline: RD_LAT memory stages plus the vn4 output register.
    logic              pipe_vld  [RD_LAT:0];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT:0];
    logic              upstream_vld;

    // Any valid entry that has not yet reached the write stage.
    always_comb begin
        upstream_vld = rd_en_reg;
        for (int i = 0; i < RD_LAT; i++) begin
            upstream_vld = upstream_vld | pipe_vld[i];
        end
    end

    // Next-state and registered-output decode; abort overrides everything.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rd_en_next    = 1'b0;
        rd_addr_next  = rd_addr_reg;
        cn_start_next = 1'b0;
        done_next     = 1'b0;
        success_next  = success_reg;
        iter_next     = iter_reg;
        flush         = 1'b0;
        if (abort && (state_reg != S_IDLE)) begin
            state_next   = S_IDLE;
            success_next = 1'b0;
            flush        = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next    = S_CN_WAIT;
                        cn_start_next = 1'b1;
                        iter_next     = ITER_W'(1);
                        success_next  = 1'b0;
                    end
                end
                S_CN_WAIT: begin
                    // Address 0 is issued on entry so reads start the cycle after cn_done.
                    if (cn_done) begin
                        state_next   = S_VN_RD;
                        rd_en_next   = 1'b1;
                        rd_addr_next = '0;
                        cnt_next     = ADDR_W'(1);
                    end
                end
                S_VN_RD: begin
                    if (!stall) begin
                        rd_en_next   = 1'b1;
                        rd_addr_next = cnt_reg;
                        cnt_next     = cnt_reg + ADDR_W'(1);
                        if (cnt_reg == LAST_ADDR) begin
                            state_next = S_VN_DRAIN;
                        end
                    end
                end
                S_VN_DRAIN: begin
                    // Leave while the last write is on the output; CHECK follows it.
                    if (!upstream_vld) begin
                        state_next = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (syndrome_ok) begin
                        state_next   = S_DONE;
                        success_next = 1'b1;
                        done_next    = 1'b1;
                    end else if (iter_reg == ITER_LIMIT) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next    = S_CN_WAIT;
                        cn_start_next = 1'b1;
                        iter_next     = iter_reg + ITER_W'(1);
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            cn_start_reg <= 1'b0;
            done_reg     <= 1'b0;
            success_reg  <= 1'b0;
            iter_reg     <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_en_reg    <= rd_en_next;
            rd_addr_reg  <= rd_addr_next;
            cn_start_reg <= cn_start_next;
            done_reg     <= done_next;
            success_reg  <= success_next;
            iter_reg     <= iter_next;
            busy_reg     <= busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= RD_LAT; gi++) begin : g_pipe
            logic              vld_in;
            logic [ADDR_W-1:0] addr_in;
            if (gi == 0) begin : g_head
                assign vld_in  = rd_en_reg;
                assign addr_in = rd_addr_reg;
            end else begin : g_tail
                assign vld_in  = pipe_vld[gi-1];
                assign addr_in = pipe_addr[gi-1];
            end
            // One pipeline stage; abort drops the valid bit so no stale write escapes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_vld[gi]  <= 1'b0;
                    pipe_addr[gi] <= '0;
                end else begin
                    pipe_vld[gi]  <= flush ? 1'b0 : vld_in;
                    pipe_addr[gi] <= addr_in;
                end
            end
        end
    endgenerate

    assign cn_start = cn_start_reg;
    assign rd_en    = rd_en_reg;
    assign rd_addr  = rd_addr_reg;
    assign wr_en    = pipe_vld[RD_LAT];
    assign wr_addr  = pipe_addr[RD_LAT];
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign success  = success_reg;
    assign iter_cnt = iter_reg;

endmodule

// File: tb/tb_vfu_sched.sv
// Directed bench for vfu_sched with COLS=4, RD_LAT=2, MAX_ITER=3.
module tb_vfu_sched;
    localparam int COLS     = 4;
    localparam int ADDR_W   = 2;
    localparam int RD_LAT   = 2;
    localparam int MAX_ITER = 3;
    localparam int ITER_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              cn_done = 1'b0;
    logic              stall = 1'b0;
    logic              syndrome_ok = 1'b0;
    logic              cn_start, rd_en, wr_en, busy, done, success;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [ITER_W-1:0] iter_cnt;

    int checks = 0;
    int errors = 0;
    int cn_start_total = 0;
    int base;

    vfu_sched #(
        .COLS(COLS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cn_start(cn_start), .cn_done(cn_done), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .syndrome_ok(syndrome_ok), .busy(busy), .done(done),
        .success(success), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cn_start) cn_start_total <= cn_start_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column index expected on the read port k cycles after cn_done, with a
    // 2-cycle hole (length s) inserted after address 1; -1 means no access.
    function automatic int exp_idx(input int k, input int s);
        if (k < 1) return -1;
        if (k <= 2) return k - 1;
        if (k < 3 + s) return -1;
        if (k - 1 - s <= COLS - 1) return k - 1 - s;
        return -1;
    endfunction

    // Pulse cn_done now and check kmax cycles of the VN phase; stall s cycles
    // after address 1; optionally drive ignored start/cn_done during VN_RD.
    task automatic vn_phase(input int s, input int kmax, input bit inject);
        int a;
        int w;
        cn_done = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            tick();
            cn_done = inject && (k == 2 || k == 3);
            start   = inject && (k == 2 || k == 3);
            a = exp_idx(k, s);
            w = exp_idx(k - (RD_LAT + 1), s);
            chk("rd_en", rd_en, a >= 0);
            if (a >= 0) chk("rd_addr", rd_addr, a);
            chk("wr_en", wr_en, w >= 0);
            if (w >= 0) chk("wr_addr", wr_addr, w);
            chk("cn_start_in_vn", cn_start, 0);
            chk("done_in_vn", done, 0);
            chk("busy_in_vn", busy, 1);
            stall = (k >= 2 && k < 2 + s);
        end
        cn_done = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_cn_start", cn_start, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_success", success, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        tick();
        rst = 1'b0;
        tick();

        // Early exit: cn_done 5 cycles after start, syndrome passes
        syndrome_ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ee_cn_start", cn_start, 1);
        chk("ee_busy", busy, 1);
        chk("ee_iter_start", iter_cnt, 1);
        repeat (4) begin
            tick();
            chk("ee_cn_start_once", cn_start, 0);
        end
        vn_phase(0, 8, 1'b0);
        tick();
        chk("ee_done", done, 1);
        chk("ee_success", success, 1);
        chk("ee_iter", iter_cnt, 1);
        chk("ee_no_cn_start", cn_start, 0);
        tick();
        chk("ee_busy_fall", busy, 0);
        chk("ee_done_pulse", done, 0);
        chk("ee_success_held", success, 1);
        $display("decode 1 (early exit): success=%0d iter=%0d", success, iter_cnt);

        // Iteration limit: syndrome never passes
        base = cn_start_total;
        syndrome_ok = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("il_cn_start", cn_start, 1);
        chk("il_success_clr", success, 0);
        chk("il_iter1", iter_cnt, 1);
        for (int it = 1; it <= MAX_ITER; it++) begin
            vn_phase(0, 8, 1'b0);
            tick();
            if (it < MAX_ITER) begin
                chk("il_next_cn_start", cn_start, 1);
                chk("il_iter_inc", iter_cnt, it + 1);
                chk("il_no_done", done, 0);
            end else begin
                chk("il_done", done, 1);
                chk("il_success", success, 0);
                chk("il_iter_final", iter_cnt, 3);
                chk("il_no_4th_cn", cn_start, 0);
            end
        end
        repeat (4) tick();
        chk("il_busy_idle", busy, 0);
        chk("il_iter_held", iter_cnt, 3);
        chk("il_cn_start_count", cn_start_total - base, 3);
        $display("decode 2 (iteration limit): success=%0d iter=%0d", success, iter_cnt);

        // Stall for 2 cycles after address 1; CHECK moves 2 cycles later
        syndrome_ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_cn_start", cn_start, 1);
        vn_phase(2, 10, 1'b0);
        tick();
        chk("st_done", done, 1);
        chk("st_success", success, 1);
        chk("st_iter", iter_cnt, 1);
        tick();
        $display("decode 3 (stall): success=%0d iter=%0d", success, iter_cnt);

        // Ignored inputs, then abort in VN_DRAIN of iteration 2 after 2 writes
        syndrome_ok = 1'b0;
        start = 1'b1;
        tick();
        chk("ig_cn_start", cn_start, 1);
        tick();
        start = 1'b0;
        chk("ig_start_in_cn_wait", cn_start, 0);
        chk("ig_busy", busy, 1);
        vn_phase(0, 8, 1'b1);
        tick();
        chk("ab_cn_start2", cn_start, 1);
        chk("ab_iter2", iter_cnt, 2);
        vn_phase(0, 5, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_wr_en", wr_en, 0);
        chk("ab_rd_en", rd_en, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_success", success, 0);
        chk("ab_iter_held", iter_cnt, 2);
        repeat (3) begin
            tick();
            chk("ab_no_wr", wr_en, 0);
            chk("ab_no_done", done, 0);
        end
        $display("decode 4 (abort): busy=%0d iter=%0d", busy, iter_cnt);

        // Asynchronous reset in the middle of VN_RD
        syndrome_ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vn_phase(0, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rd_en", rd_en, 0);
        chk("ar_wr_en", wr_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_iter", iter_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_cn_start", cn_start, 1);
        chk("ar_iter_start", iter_cnt, 1);
        vn_phase(0, 8, 1'b0);
        tick();
        chk("ar_done", done, 1);
        chk("ar_success", success, 1);
        chk("ar_iter_final", iter_cnt, 1);
        tick();
        chk("ar_busy_fall", busy, 0);
        $display("decode 5 (after async reset): success=%0d iter=%0d", success, iter_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vfu_sched.md
# vfu_sched

Iteration scheduler for the variable-node functional unit (VFU) of the LDPC decoder. It runs the decode loop: it starts each check-node phase, then sweeps every column group through the vn4 datapath with one memory read issued per cycle. It also generates the matching write-backs after the fixed pipeline latency, counts iterations, and ends decoding when the syndrome passes or the iteration limit is reached. It sits between the top-level decoder control and the VFU message memories and vn4 array.

## Interface
- COLS, 64, number of column groups swept per VN phase (≥2)
- ADDR_W, 6, column-group address width; 2^ADDR_W ≥ COLS
- RD_LAT, 2, message-memory read latency in cycles (≥1)
- MAX_ITER, 10, maximum decode iterations (1..2^ITER_W−1)
- ITER_W, 4, iteration counter width

Ports (reset is asynchronous and active-high):
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a codeword decode; honoured only in IDLE
- abort  in  1  cancel the decode; returns to IDLE next cycle
- cn_start  out  1  one-cycle pulse that launches the check-node phase
- cn_done  in  1  one-cycle pulse marking the end of the CN phase; honoured only in CN_WAIT
- stall  in  1  suppresses new read issue in VN_RD; in-flight reads still complete
- rd_en  out  1  message/LLR memory read strobe
- rd_addr  out  ADDR_W  column group being read
- wr_en  out  1  VN result write strobe (vn_1..4 and cn_all_sum registered)
- wr_addr  out  ADDR_W  column group being written
- syndrome_ok  in  1  parity-check result; sampled only in CHECK
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the decode ends
- success  out  1  decode ended on syndrome_ok; held until the next start
- iter_cnt  out  ITER_W  current or final iteration number; held until the next start

## Operation
- States: IDLE, CN_WAIT, VN_RD, VN_DRAIN, CHECK, DONE.
- IDLE, start=1 → CN_WAIT. In the same transition: cn_start=1 for one cycle, iter_cnt←1, success←0.
- CN_WAIT, cn_done=1 → VN_RD, with the read address counter at 0.
- VN_RD:
  - Each cycle with stall=0, assert rd_en with rd_addr = counter, then increment the counter.
  - When stall=1, rd_en=0 and the counter holds.
  - After address COLS−1 is issued → VN_DRAIN.
- Write pipeline: a shift register RD_LAT+1 deep carries rd_en and rd_addr. wr_en and wr_addr are the delayed copies (RD_LAT memory cycles plus 1 vn4 output register). Writes keep the order of reads, including gaps caused by stall.
- VN_DRAIN → CHECK in the cycle after the final wr_en, i.e. once the pipeline holds no valid entry.
- CHECK lasts one cycle and samples syndrome_ok:
  - syndrome_ok=1 → DONE, success←1.
  - Else if iter_cnt == MAX_ITER → DONE, success stays 0.
  - Else → CN_WAIT with cn_start=1 pulse and iter_cnt incremented.
- DONE: done=1 for one cycle, then IDLE.
- abort (any state except IDLE):
  - Next state is IDLE.
  - The pipeline valid bits are flushed, so wr_en=0 from the next cycle.
  - No done pulse; success=0; iter_cnt holds its value.
  - abort takes priority over start, cn_done and the CHECK decision.
- Ignored inputs: start outside IDLE; cn_done outside CN_WAIT; stall outside VN_RD; syndrome_ok outside CHECK.
- The address counter wraps only by reload to 0 at VN_RD entry; it is never compared beyond COLS−1.

## Timing
- Reset values: state=IDLE; cn_start, rd_en, wr_en, busy, done, success = 0; rd_addr, wr_addr, iter_cnt = 0; pipeline cleared.
- All outputs are registered.
- start sampled at cycle T → busy=1 and cn_start=1 at T+1.
- cn_done at cycle C, no stall:
  - rd_en high from C+1 to C+COLS.
  - wr_en high from C+RD_LAT+2 to C+COLS+RD_LAT+1.
  - CHECK at C+COLS+RD_LAT+2.
  - The next cn_start or the done pulse follows at C+COLS+RD_LAT+3.
- Each stalled cycle adds 1 cycle to the VN phase.
- busy falls in the cycle after the done pulse.
- rst asserted mid-decode: every output goes to its reset value immediately (asynchronously).

## Test plan
All scenarios use COLS=4, RD_LAT=2, MAX_ITER=3.
- Early exit: start, then cn_done 5 cycles later, syndrome_ok=1 in CHECK.
  - Required: rd_addr 0,1,2,3 on consecutive cycles; wr_addr 0..3 exactly 3 cycles later; done with success=1 and iter_cnt=1.
- Iteration limit: syndrome_ok held at 0.
  - Required: exactly 3 cn_start pulses; done with success=0 and iter_cnt=3; no fourth CN phase.
- Stall: stall=1 for 2 cycles after rd_addr=1.
  - Required: rd_addr sequence 0,1,–,–,2,3; wr_en shows the same gap 3 cycles later; CHECK is 2 cycles later than in the no-stall case.
- Abort in VN_DRAIN after 2 writes.
  - Required: no further wr_en; busy=0 next cycle; no done pulse; iter_cnt held.
- Ignored inputs: start during CN_WAIT and cn_done during VN_RD.
  - Required: no state change and no extra cn_start; the address sequence is unchanged.
- Async reset mid-VN_RD (rst with no clock edge).
  - Required: rd_en, wr_en and busy drop to 0 immediately; a later start runs a clean decode.
